// File: rtl/boot_loader_pkg.sv
// Shared definitions for the UART instruction-memory bootloader.
//   loader_state_t : loader FSM state encoding
//   IMEM_BASE      : default byte address of the first image word
//   LEN_BYTES      : size of the little-endian length header in bytes
package boot_loader_pkg;

  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} loader_state_t;

  localparam logic [31:0] IMEM_BASE = 32'h1000_0000;
  localparam int          LEN_BYTES = 2;

endpackage

// File: rtl/imem_word_packer.sv
// Byte-lane word packer for the bootloader's imem write port.
// Gathers payload bytes into a 32-bit little-endian word and issues a
// one-cycle write strobe one cycle after the byte that completes a word
// (lane 3) or ends the image. The address advances by 4 after each strobe.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   byte_vld          accepted payload byte this cycle
//   byte_lane         lane (0..3) the byte belongs to
//   byte_data         payload byte
//   byte_last         byte is the final payload byte of the image
//   imem_we           one-cycle write strobe
//   imem_addr         word-aligned byte address of the write
//   imem_wdata        packed word
//   imem_be           lanes filled in the written word
module imem_word_packer #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_vld,
  input  logic [1:0]        byte_lane,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [3:0]        imem_be
);

  logic [31:0]       buf_q, buf_d;
  logic [3:0]        be_acc_q, be_acc_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       merged;
  logic [3:0]        merged_be;

  always_comb begin
    buf_d     = buf_q;
    be_acc_d  = be_acc_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    be_d      = be_q;
    addr_d    = addr_q;
    merged    = buf_q | ({24'b0, byte_data} << {byte_lane, 3'b000});
    merged_be = be_acc_q | (4'b0001 << byte_lane);
    // The address holds during the strobe and moves on right after it.
    if (we_q) addr_d = addr_q + ADDR_W'(4);
    if (byte_vld) begin
      if (byte_lane == 2'd3 || byte_last) begin
        // Write from registered data; the buffer clears now so a byte
        // arriving during the strobe cycle lands in an empty word.
        we_d     = 1'b1;
        wdata_d  = merged;
        be_d     = merged_be;
        buf_d    = '0;
        be_acc_d = '0;
      end else begin
        buf_d    = merged;
        be_acc_d = merged_be;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q    <= '0;
      be_acc_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      addr_q   <= ADDR_W'(BASE_ADDR);
    end else begin
      buf_q    <= buf_d;
      be_acc_q <= be_acc_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign imem_be    = be_q;

endmodule

// File: rtl/uart_imem_loader.sv
// UART bootloader: receives a little-endian 16-bit length header followed by
// the payload, writes the payload into instruction RAM from BASE_ADDR, and
// holds the core in reset until the image is complete.
// Optional feature macro CHECKSUM_EN: a trailing byte must equal the XOR of
// all payload bytes; mismatch ends in ERR.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   rx_valid      one-cycle strobe, rx_data holds a received byte
//   rx_data       received byte
//   imem_we       one-cycle imem write strobe
//   imem_addr     word-aligned byte address
//   imem_wdata    little-endian packed word
//   imem_be       byte enables of the written word
//   core_rst      held high until the load completes
//   load_done     image loaded (sticky until rst)
//   load_err      load failed (sticky until rst)
//   byte_cnt      payload bytes accepted so far
module uart_imem_loader
  import boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IMEM_BASE,
  parameter int          MAX_BYTES = 4096,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [3:0]        imem_be,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       byte_cnt
);

  loader_state_t state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          core_rst_q, core_rst_d;
  logic [15:0]   cnt_inc;
  logic [15:0]   len_full;
  logic          pack_vld;
  logic          pack_last;
`ifdef CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    pack_vld  = 1'b0;
    pack_last = 1'b0;
    cnt_inc   = cnt_q + 16'd1;
    len_full  = {rx_data, len_q[7:0]};
`ifdef CHECKSUM_EN
    csum_d    = csum_q;
`endif
    // Core leaves reset one cycle after DONE is entered, i.e. after the
    // final write strobe has been issued.
    core_rst_d = (state_q != DONE);
    case (state_q)
      LEN_LO: if (rx_valid) begin
        len_d[7:0] = rx_data;
        state_d    = LEN_HI;
      end
      LEN_HI: if (rx_valid) begin
        len_d = len_full;
        if (len_full == 16'd0) begin
`ifdef CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else if ({16'b0, len_full} > 32'(MAX_BYTES)) begin
          state_d = ERR;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (rx_valid) begin
        pack_vld  = 1'b1;
        pack_last = (cnt_inc == len_q);
        cnt_d     = cnt_inc;
`ifdef CHECKSUM_EN
        csum_d    = csum_q ^ rx_data;
        if (pack_last) state_d = CHK;
`else
        if (pack_last) state_d = DONE;
`endif
      end
`ifdef CHECKSUM_EN
      CHK: if (rx_valid) begin
        state_d = (rx_data == csum_q) ? DONE : ERR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LEN_LO;
      len_q      <= '0;
      cnt_q      <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      core_rst_q <= core_rst_d;
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  imem_word_packer #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_vld   (pack_vld),
    .byte_lane  (cnt_q[1:0]),
    .byte_data  (rx_data),
    .byte_last  (pack_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_be    (imem_be)
  );

  assign core_rst  = core_rst_q;
  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERR);
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
module tb_uart_imem_loader;

`ifdef CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int BIG = 1 << 30;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [3:0]  imem_be;
  logic        core_rst;
  logic        load_done;
  logic        load_err;
  logic [15:0] byte_cnt;

  uart_imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_be    (imem_be),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_err   (load_err),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Image model: phases 0=len lo, 1=len hi, 2=payload, 3=trailer, 4=done, 5=error
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  int          m_phase;
  logic [15:0] m_len;
  logic [15:0] m_cnt;
  logic [31:0] m_word;
  logic [3:0]  m_be;
  logic [7:0]  m_xor;
  int          m_done_cyc;
  int          m_err_cyc;

  int          n_wr;
  logic [31:0] first_addr, first_data, last_addr, last_data;
  logic [3:0]  first_be, last_be;

  task automatic model_reset();
    exp_q.delete();
    m_phase = 0; m_len = '0; m_cnt = '0; m_word = '0; m_be = '0; m_xor = '0;
    m_done_cyc = BIG; m_err_cyc = BIG;
    n_wr = 0;
    first_addr = '0; first_data = '0; first_be = '0;
    last_addr = '0; last_data = '0; last_be = '0;
  endtask

  // b is sampled by the DUT at the edge that ends cycle n.
  task automatic model_byte(input logic [7:0] b, input int n);
    wr_t w;
    int  lane;
    case (m_phase)
      0: begin m_len[7:0] = b; m_phase = 1; end
      1: begin
        m_len[15:8] = b;
        if (m_len == 0) begin
          if (CK) m_phase = 3;
          else begin m_phase = 4; m_done_cyc = n + 1; end
        end else if (m_len > 16'd4096) begin
          m_phase = 5; m_err_cyc = n + 1;
        end else m_phase = 2;
      end
      2: begin
        lane = int'(m_cnt % 4);
        w.addr = BASE + 32'((m_cnt / 4) * 4);
        m_word[8*lane +: 8] = b;
        m_be[lane] = 1'b1;
        m_xor = m_xor ^ b;
        m_cnt = m_cnt + 1;
        if (lane == 3 || m_cnt == m_len) begin
          w.cyc = n + 1; w.data = m_word; w.be = m_be;
          exp_q.push_back(w);
          m_word = '0; m_be = '0;
        end
        if (m_cnt == m_len) begin
          if (CK) m_phase = 3;
          else begin m_phase = 4; m_done_cyc = n + 1; end
        end
      end
      3: begin
        if (b == m_xor) begin m_phase = 4; m_done_cyc = n + 1; end
        else begin m_phase = 5; m_err_cyc = n + 1; end
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("load_done", 32'(load_done), 32'(cyc >= m_done_cyc));
      chk("load_err", 32'(load_err), 32'(cyc >= m_err_cyc));
      chk("core_rst", 32'(core_rst), 32'(!(cyc >= m_done_cyc + 1)));
      if (imem_we) begin
        n_wr++;
        if (n_wr == 1) begin first_addr = imem_addr; first_data = imem_wdata; first_be = imem_be; end
        last_addr = imem_addr; last_data = imem_wdata; last_be = imem_be;
        if (exp_q.size() == 0) chk("unexpected_we", 32'(imem_we), 32'd0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("we_cycle", 32'(cyc), 32'(e.cyc));
          chk("we_addr", imem_addr, e.addr);
          chk("we_data", imem_wdata, e.data);
          chk("we_be", 32'(imem_be), 32'(e.be));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_we", 32'(imem_we), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    model_byte(b, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; rx_valid = 1'b0; end
  endtask

  task automatic sendg(input logic [7:0] b);
    send(b);
    idle(2);
  endtask

  task automatic trailer();
    logic [7:0] x;
    x = m_xor;
    if (CK) sendg(x);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic end_check(input string name);
    idle(3);
    chk({name, "_byte_cnt"}, 32'(byte_cnt), 32'(m_cnt));
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);

    // T1: single full word
    sendg(8'h04); sendg(8'h00);
    sendg(8'h13); sendg(8'h00); sendg(8'h00); sendg(8'h00);
    trailer();
    end_check("t1");
    chk("t1_nwr", 32'(n_wr), 32'd1);
    chk("t1_addr", last_addr, 32'h1000_0000);
    chk("t1_data", last_data, 32'h0000_0013);
    chk("t1_be", 32'(last_be), 32'hF);
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_core_rst", 32'(core_rst), 32'd0);

    // T2: two words, 44 and 55 back to back so 55 lands in the strobe cycle
    do_reset();
    sendg(8'h06); sendg(8'h00);
    sendg(8'h11); sendg(8'h22); sendg(8'h33);
    send(8'h44); send(8'h55); idle(2);
    sendg(8'h66);
    trailer();
    end_check("t2");
    chk("t2_nwr", 32'(n_wr), 32'd2);
    chk("t2_addr0", first_addr, 32'h1000_0000);
    chk("t2_data0", first_data, 32'h4433_2211);
    chk("t2_be0", 32'(first_be), 32'hF);
    chk("t2_addr1", last_addr, 32'h1000_0004);
    chk("t2_data1", last_data, 32'h0000_6655);
    chk("t2_be1", 32'(last_be), 32'h3);
    chk("t2_cnt", 32'(byte_cnt), 32'd6);

    // T3: empty image
    do_reset();
    sendg(8'h00); sendg(8'h00);
    trailer();
    end_check("t3");
    chk("t3_nwr", 32'(n_wr), 32'd0);
    chk("t3_done", 32'(load_done), 32'd1);
    chk("t3_cnt", 32'(byte_cnt), 32'd0);

    // T4: oversize header, following bytes ignored
    do_reset();
    sendg(8'h01); sendg(8'h10);
    sendg(8'h11); sendg(8'h22); sendg(8'h33);
    end_check("t4");
    chk("t4_err", 32'(load_err), 32'd1);
    chk("t4_core_rst", 32'(core_rst), 32'd1);
    chk("t4_nwr", 32'(n_wr), 32'd0);
    chk("t4_cnt", 32'(byte_cnt), 32'd0);

    // T4b: exactly MAX_BYTES is accepted
    do_reset();
    sendg(8'h00); sendg(8'h10);
    sendg(8'h5A);
    end_check("t4b");
    chk("t4b_err", 32'(load_err), 32'd0);
    chk("t4b_done", 32'(load_done), 32'd0);
    chk("t4b_cnt", 32'(byte_cnt), 32'd1);

    // T5: async reset mid-payload, then a fresh short image
    do_reset();
    sendg(8'h08); sendg(8'h00);
    sendg(8'h01); sendg(8'h02); sendg(8'h03);
    @(posedge clk); #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_rst_we", 32'(imem_we), 32'd0);
    chk("t5_rst_addr", imem_addr, 32'h1000_0000);
    chk("t5_rst_wdata", imem_wdata, 32'd0);
    chk("t5_rst_be", 32'(imem_be), 32'd0);
    chk("t5_rst_core_rst", 32'(core_rst), 32'd1);
    chk("t5_rst_done", 32'(load_done), 32'd0);
    chk("t5_rst_err", 32'(load_err), 32'd0);
    chk("t5_rst_cnt", 32'(byte_cnt), 32'd0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    sendg(8'h02); sendg(8'h00);
    sendg(8'hAA); sendg(8'hBB);
    trailer();
    end_check("t5");
    chk("t5_nwr", 32'(n_wr), 32'd1);
    chk("t5_addr", last_addr, 32'h1000_0000);
    chk("t5_data", last_data, 32'h0000_BBAA);
    chk("t5_be", 32'(last_be), 32'h3);
    chk("t5_done", 32'(load_done), 32'd1);

`ifdef CHECKSUM_EN
    // T6: checksum trailer match and mismatch
    do_reset();
    sendg(8'h03); sendg(8'h00);
    sendg(8'h01); sendg(8'h02); sendg(8'h03);
    sendg(8'h00);
    end_check("t6a");
    chk("t6a_done", 32'(load_done), 32'd1);
    chk("t6a_core_rst", 32'(core_rst), 32'd0);

    do_reset();
    sendg(8'h03); sendg(8'h00);
    sendg(8'h01); sendg(8'h02); sendg(8'h03);
    sendg(8'h01);
    end_check("t6b");
    chk("t6b_err", 32'(load_err), 32'd1);
    chk("t6b_core_rst", 32'(core_rst), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
